// File: rtl/traffic_control_param.sv
// -----------------------------------------------------------------------------
// traffic_control_param
//
// N-way traffic light controller. The grant rotates GREEN -> YELLOW ->
// ALL_RED -> GREEN. The phase durations and the number of directions are
// parameters. When SENSOR_MODE=1, the vehicle-present inputs choose the next
// direction, and a green is held while no other direction is waiting.
//
// Optional build macro: TRAFFIC_EMERG_EN
//   When this macro is defined, the design adds emergency pre-emption and an
//   EMERG state (phase 11). When it is undefined, emerg_req and emerg_dir are
//   ignored and phase never reads 11.
//
// Ports:
//   clk          system clock; all state updates on posedge
//   rst_a        asynchronous, active-low reset
//   veh_req      per-direction vehicle-present level (bit i = direction i)
//   emerg_req    emergency pre-emption request (level)
//   emerg_dir    direction requested by the emergency
//   lights       lamp codes, lights[3i+2:3i] = direction i
//                (001 green, 010 yellow, 100 red)
//   active_dir   direction that currently owns the non-red lamp
//   phase        00 green, 01 yellow, 10 all-red, 11 emergency green
//   green_start  one-cycle pulse on the first green cycle of a new grant
//
// All outputs decode from registered state only. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module traffic_control_param #(
    parameter int N_DIR       = 4,
    parameter int GREEN_CYC   = 8,
    parameter int YELLOW_CYC  = 4,
    parameter int ALL_RED_CYC = 2,
    parameter int SENSOR_MODE = 1,
    parameter int DIR_W       = $clog2(N_DIR)
) (
    input  logic                 clk,
    input  logic                 rst_a,
    input  logic [N_DIR-1:0]     veh_req,
    input  logic                 emerg_req,
    input  logic [DIR_W-1:0]     emerg_dir,
    output logic [3*N_DIR-1:0]   lights,
    output logic [DIR_W-1:0]     active_dir,
    output logic [1:0]           phase,
    output logic                 green_start
);

    localparam int CNT_MAX = (GREEN_CYC > YELLOW_CYC)
                             ? ((GREEN_CYC > ALL_RED_CYC) ? GREEN_CYC : ALL_RED_CYC)
                             : ((YELLOW_CYC > ALL_RED_CYC) ? YELLOW_CYC : ALL_RED_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int AR_LAST = (ALL_RED_CYC > 0) ? ALL_RED_CYC - 1 : 0;

    // The state encoding is the phase code, so phase is simply the state.
    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_ALL_RED = 2'b10,
        ST_EMERG   = 2'b11
    } state_t;

    state_t             r_state;
    logic [DIR_W-1:0]   r_cur_dir;
    logic [DIR_W-1:0]   r_next_dir;
    logic [CNT_W-1:0]   r_count;
    logic               r_green_start;

    state_t             w_state_nxt;
    logic [DIR_W-1:0]   w_cur_nxt;
    logic [DIR_W-1:0]   w_next_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_gs_nxt;
    logic               w_grant;

    logic               w_green_last;
    logic               w_yellow_last;
    logic               w_ar_last;
    logic [DIR_W-1:0]   w_rr;
    logic               w_found;
    logic [DIR_W-1:0]   w_sel;
    logic [DIR_W:0]     w_sum;

    assign w_green_last  = (r_count == CNT_W'(GREEN_CYC - 1));
    assign w_yellow_last = (r_count == CNT_W'(YELLOW_CYC - 1));
    assign w_ar_last     = (r_count == CNT_W'(AR_LAST));

    assign w_rr = (r_cur_dir == DIR_W'(N_DIR - 1)) ? '0 : r_cur_dir + DIR_W'(1);

`ifdef TRAFFIC_EMERG_EN
    logic w_emerg_valid;
    // An emergency index outside the direction range counts as no request.
    generate
        if (N_DIR == (1 << DIR_W)) begin : g_emerg_full
            assign w_emerg_valid = emerg_req;
        end else begin : g_emerg_range
            assign w_emerg_valid = emerg_req && (emerg_dir < DIR_W'(N_DIR));
        end
    endgenerate
`else
    logic w_unused_emerg;
    assign w_unused_emerg = ^{emerg_req, emerg_dir};
`endif

    // Round-robin search for the next waiting direction. The search starts
    // at cur_dir+1 and wraps around. It never returns cur_dir itself.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_cur_dir;
        w_sum   = '0;
        for (int k = 1; k < N_DIR; k++) begin
            w_sum = {1'b0, r_cur_dir} + (DIR_W+1)'(k);
            if (w_sum >= (DIR_W+1)'(N_DIR)) begin
                w_sum = w_sum - (DIR_W+1)'(N_DIR);
            end
            if (!w_found && veh_req[w_sum[DIR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[DIR_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_dir;
        w_next_nxt  = r_next_dir;
        w_count_nxt = r_count + CNT_W'(1);
        w_gs_nxt    = 1'b0;
        w_grant     = 1'b0;

        case (r_state)
            ST_GREEN: begin
`ifdef TRAFFIC_EMERG_EN
                if (w_emerg_valid && (emerg_dir == r_cur_dir)) begin
                    // The emergency direction already has green, so keep
                    // the lamp as it is and only change the phase.
                    w_state_nxt = ST_EMERG;
                    w_count_nxt = '0;
                end else if (w_emerg_valid) begin
                    w_state_nxt = ST_YELLOW;
                    w_count_nxt = '0;
                    w_next_nxt  = emerg_dir;
                end else
`endif
                if (w_green_last) begin
                    // If nobody else is waiting, the green is held: the count
                    // restarts and no new grant is made.
                    w_count_nxt = '0;
                    if (SENSOR_MODE == 0) begin
                        w_next_nxt  = w_rr;
                        w_state_nxt = ST_YELLOW;
                    end else if (w_found) begin
                        w_next_nxt  = w_sel;
                        w_state_nxt = ST_YELLOW;
                    end
                end
            end

            ST_YELLOW: begin
`ifdef TRAFFIC_EMERG_EN
                if (w_emerg_valid) begin
                    w_next_nxt = emerg_dir;
                end
`endif
                if (w_yellow_last) begin
                    w_count_nxt = '0;
                    if (ALL_RED_CYC == 0) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = ST_ALL_RED;
                    end
                end
            end

            ST_ALL_RED: begin
`ifdef TRAFFIC_EMERG_EN
                if (w_emerg_valid) begin
                    w_next_nxt = emerg_dir;
                end
`endif
                if (w_ar_last) begin
                    w_count_nxt = '0;
                    w_grant     = 1'b1;
                end
            end

`ifdef TRAFFIC_EMERG_EN
            ST_EMERG: begin
                if (w_emerg_valid) begin
                    w_count_nxt = r_count;
                end else begin
                    // After the emergency, rotation resumes from the
                    // emergency direction.
                    w_state_nxt = ST_YELLOW;
                    w_count_nxt = '0;
                    w_next_nxt  = ((SENSOR_MODE != 0) && w_found) ? w_sel : w_rr;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_GREEN;
                w_count_nxt = '0;
            end
        endcase

        if (w_grant) begin
            w_cur_nxt   = w_next_nxt;
            w_state_nxt = ST_GREEN;
            w_gs_nxt    = 1'b1;
`ifdef TRAFFIC_EMERG_EN
            if (w_emerg_valid) begin
                w_state_nxt = ST_EMERG;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_state       <= ST_GREEN;
            r_cur_dir     <= '0;
            r_next_dir    <= '0;
            r_count       <= '0;
            r_green_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur_dir     <= w_cur_nxt;
            r_next_dir    <= w_next_nxt;
            r_count       <= w_count_nxt;
            r_green_start <= w_gs_nxt;
        end
    end

    assign active_dir  = r_cur_dir;
    assign phase       = r_state;
    assign green_start = r_green_start;

    // During ALL_RED every lamp is red. In the other states, only cur_dir
    // shows a non-red lamp.
    generate
        for (genvar gi = 0; gi < N_DIR; gi++) begin : g_lamp
            assign lights[3*gi +: 3] =
                ((r_state != ST_ALL_RED) && (r_cur_dir == DIR_W'(gi)))
                ? ((r_state == ST_YELLOW) ? 3'b010 : 3'b001)
                : 3'b100;
        end
    endgenerate

endmodule

// File: doc/traffic_control_param.md
Name: traffic_control_param

Overview:
Parametrised N-way traffic light controller, successor to the fixed 4-way rotating controller. Direction count and green/yellow/all-red durations are parameters. Adds vehicle-sensor-driven direction skipping and green hold, plus an optional emergency pre-emption path. Sits at the top of the intersection control tree and drives the lamp drivers directly.

Parameters:
N_DIR, 4, number of directions; legal range >=2
GREEN_CYC, 8, green duration in clk cycles; >=1
YELLOW_CYC, 4, yellow duration in clk cycles; >=1
ALL_RED_CYC, 2, all-red clearance duration in clk cycles; 0 removes the phase
SENSOR_MODE, 1, 1 = veh_req drives skip/hold; 0 = plain round-robin with veh_req ignored
DIR_W, $clog2(N_DIR), derived width of direction index

Ports:
clk  input  1  system clock; all state updates on posedge
rst_a  input  1  asynchronous, active-low reset
veh_req  input  N_DIR  per-direction vehicle-present level, bit i = direction i
emerg_req  input  1  emergency pre-emption request, level (honoured only with TRAFFIC_EMERG_EN)
emerg_dir  input  DIR_W  direction requested by emergency
lights  output  3*N_DIR  lamp codes, lights[3i+2:3i] = direction i; 001 green, 010 yellow, 100 red
active_dir  output  DIR_W  direction currently owning the non-red lamp
phase  output  2  00 green, 01 yellow, 10 all-red, 11 emergency green
green_start  output  1  one-cycle pulse on the first green cycle of a newly granted direction

Behaviour:
- Outputs decode combinationally from registered state (state, cur_dir, next_dir, count). No glitch path from inputs to outputs.
- Reset (rst_a=0, asynchronous): state GREEN, cur_dir=0, count=0, green_start=0. lights: dir0=001, all others=100. phase=00.
- Exactly one direction is non-red in GREEN/YELLOW/EMERG. All directions are 100 in ALL_RED.
- Counter width is sized for max(GREEN_CYC, YELLOW_CYC, ALL_RED_CYC). count resets to 0 on every state change.
- GREEN: lasts GREEN_CYC cycles (count 0..GREEN_CYC-1). On the last cycle, select the next direction:
  - SENSOR_MODE=0: next_dir = (cur_dir+1) mod N_DIR. Go to YELLOW.
  - SENSOR_MODE=1: search round-robin from cur_dir+1, wrapping, excluding cur_dir, for the first set veh_req bit.
    - Found: latch it into next_dir and go to YELLOW.
    - None found: green hold. Stay GREEN, count restarts at 0, no green_start pulse.
- YELLOW: cur_dir=010 for YELLOW_CYC cycles, then ALL_RED. If ALL_RED_CYC=0, go directly to GREEN.
- ALL_RED: ALL_RED_CYC cycles, then GREEN with cur_dir<=next_dir.
- green_start: asserted during the first GREEN cycle after YELLOW/ALL_RED/EMERG entry. Never asserted after reset or on a hold restart.
- veh_req is sampled only on the last green cycle. Changes at other times have no effect on the selection.
- Default timing (8/4/2): a full slot is 14 cycles. Direction wraps N_DIR-1 -> 0.

Optional Feature:
Macro TRAFFIC_EMERG_EN.

With TRAFFIC_EMERG_EN defined, emerg_req is sampled every cycle. emerg_dir >= N_DIR is treated as no request.
- In GREEN, cur_dir==emerg_dir: go to EMERG next cycle (same lamp, phase=11, no green_start).
- In GREEN, other direction: abort green and go to YELLOW next cycle. Force next_dir=emerg_dir, then ALL_RED, then EMERG.
- In YELLOW or ALL_RED: finish the current phase, with next_dir overridden to emerg_dir. Then go to EMERG.
- EMERG: emerg_dir green, phase=11, count frozen while emerg_req=1. green_start pulses on entry from ALL_RED/YELLOW.
- emerg_req falls: go to YELLOW on emerg_dir. Round-robin resumes from emerg_dir.

Without the macro: emerg_req and emerg_dir are ignored, the EMERG state is not synthesised, and phase never equals 11.

Test Plan:
1. Reset, defaults, veh_req=all 1 -> lights dir0=001, others 100 while rst_a=0. After release: 8 cycles green, 4 yellow, 2 all-red, dir1 green with green_start on cycle 15. Sequence 0,1,2,3,0 repeats.
2. veh_req=0 -> dir0 stays 001 for 100 cycles with no yellow. Set veh_req=0100 -> yellow at next green end, then dir2 green (dir1 skipped).
3. cur_dir=3 green, veh_req=0001 -> next green is dir0 (wrap). SENSOR_MODE=0 with veh_req=0 -> rotation continues regardless.
4. Assert rst_a=0 mid-yellow on dir2 -> lights revert to dir0=001 without waiting for a clock edge. After release, timing restarts at count 0.
5. TRAFFIC_EMERG_EN, dir0 green at count 3, emerg_req=1, emerg_dir=2 -> dir0 yellow next cycle for 4 cycles, all-red 2, then dir2 green with phase=11 held 20 cycles. Drop emerg_req -> dir2 yellow, then dir3 green.
6. ALL_RED_CYC=0, N_DIR=3 -> yellow goes directly to next green, 12-cycle slots. Rotation is 0,1,2,0.
